// File: rtl/xc_aessub_pkg.sv
// rtl/xc_aessub_pkg.sv - shared types and constants for the AES SubBytes scheduler
//
// Holds the scheduler state encoding, the datapath width and the largest
// supported requester count.
package xc_aessub_pkg;

  localparam int XC_AESSUB_XLEN     = 32;
  localparam int XC_AESSUB_MAX_NREQ = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/xc_aessub_rr_arb.sv
// rtl/xc_aessub_rr_arb.sv - combinational round-robin arbiter
//
// Grants the first requester at or after ptr, wrapping modulo NREQ.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - round-robin start index
//   grant - one-hot grant (all zero when req is zero)
//   idx   - index of the granted requester (0 when req is zero)
module xc_aessub_rr_arb #(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int IW = $clog2(NREQ);

  // One spare bit so ptr + offset cannot overflow before the wrap.
  logic [IW:0]   sum;
  logic [IW-1:0] cand;

  // Scan from the farthest offset down to offset 0 so that the nearest
  // requester to ptr is the one left standing.
  always_comb begin
    grant = '0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (IW + 1)'(k);
      if (sum >= (IW + 1)'(NREQ)) begin
        sum = sum - (IW + 1)'(NREQ);
      end
      cand = sum[IW-1:0];
      if (req[cand]) begin
        grant       = '0;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/xc_aessub_sched.sv
// rtl/xc_aessub_sched.sv - round-robin scheduler sharing one AES SubBytes unit
//
// Arbitrates NREQ requesters onto a single SubBytes unit, holds the winner's
// operands stable for the whole operation and buffers the result until the
// owner acknowledges it. Works with any unit latency (su_ready handshake).
// Optional feature macro: XC_AESSUB_SCHED_FLUSH_EN (enables flush abort).
// Ports:
//   clock, reset          - clock, synchronous active-high reset
//   flush                 - abort in-flight operation (flush builds only)
//   req_valid/req_ready   - per-requester request handshake (ready one-hot)
//   req_rs1/req_rs2       - per-requester operands, 32 bits each, packed
//   req_enc/req_rot       - per-requester encrypt and rotate selects
//   rsp_valid/rsp_ready   - per-requester response handshake (valid one-hot)
//   rsp_data              - buffered result shared by all requesters
//   su_*                  - shared SubBytes unit port
//   busy                  - scheduler not idle
//   owner                 - index of the current owner
module xc_aessub_sched
  import xc_aessub_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [32*NREQ-1:0]       req_rs1,
  input  logic [32*NREQ-1:0]       req_rs2,
  input  logic [NREQ-1:0]          req_enc,
  input  logic [NREQ-1:0]          req_rot,
  output logic [NREQ-1:0]          rsp_valid,
  input  logic [NREQ-1:0]          rsp_ready,
  output logic [31:0]              rsp_data,
  output logic                     su_valid,
  output logic [31:0]              su_rs1,
  output logic [31:0]              su_rs2,
  output logic                     su_enc,
  output logic                     su_rot,
  input  logic                     su_ready,
  input  logic [31:0]              su_result,
  output logic                     su_flush,
  output logic [31:0]              su_flush_data,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);

  localparam int IW   = $clog2(NREQ);
  localparam int XLEN = XC_AESSUB_XLEN;

  state_t            state, state_next;
  logic [IW-1:0]     rr_ptr, owner_q, grant_idx;
  logic [NREQ-1:0]   grant;
  logic [XLEN-1:0]   rs1_q, rs2_q, rsp_data_q;
  logic              enc_q, rot_q;
  logic              load_op, load_rsp, advance_ptr, flush_act;

`ifdef XC_AESSUB_SCHED_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  xc_aessub_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      owner_q    <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      enc_q      <= 1'b0;
      rot_q      <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state <= state_next;
      if (load_op) begin
        owner_q <= grant_idx;
        rs1_q   <= req_rs1[int'(grant_idx)*XLEN +: XLEN];
        rs2_q   <= req_rs2[int'(grant_idx)*XLEN +: XLEN];
        enc_q   <= req_enc[grant_idx];
        rot_q   <= req_rot[grant_idx];
      end
      if (load_rsp) begin
        rsp_data_q <= su_result;
      end
      if (advance_ptr) begin
        if (owner_q == IW'(NREQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= owner_q + IW'(1);
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    req_ready   = '0;
    rsp_valid   = '0;
    su_valid    = 1'b0;
    load_op     = 1'b0;
    load_rsp    = 1'b0;
    advance_ptr = 1'b0;
    case (state)
      IDLE: begin
        if (|req_valid) begin
          req_ready  = grant;
          load_op    = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        su_valid = 1'b1;
        if (su_ready) begin
          load_rsp   = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        rsp_valid[owner_q] = 1'b1;
        if (rsp_ready[owner_q]) begin
          advance_ptr = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Abort wins over every handshake; rr_ptr is left where it was.
    if (flush_act) begin
      req_ready   = '0;
      load_op     = 1'b0;
      load_rsp    = 1'b0;
      advance_ptr = 1'b0;
      state_next  = IDLE;
    end
  end

  assign su_rs1        = rs1_q;
  assign su_rs2        = rs2_q;
  assign su_enc        = enc_q;
  assign su_rot        = rot_q;
  assign su_flush      = flush_act;
  assign su_flush_data = '0;
  assign rsp_data      = rsp_data_q;
  assign busy          = (state != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_xc_aessub_sched.sv
// tb/tb_xc_aessub_sched.sv - directed self-checking bench for xc_aessub_sched
module tb_xc_aessub_sched;

  localparam int NREQ = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              flush = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_rs1 = '0;
  logic [32*NREQ-1:0] req_rs2 = '0;
  logic [NREQ-1:0]   req_enc = '0;
  logic [NREQ-1:0]   req_rot = '0;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready = '0;
  logic [31:0]       rsp_data;
  logic              su_valid;
  logic [31:0]       su_rs1, su_rs2;
  logic              su_enc, su_rot;
  logic              su_ready;
  logic [31:0]       su_result;
  logic              su_flush;
  logic [31:0]       su_flush_data;
  logic              busy;
  logic [0:0]        owner;

  int n_cmp = 0;
  int n_err = 0;

  // Unit latency in BUSY cycles (1 = single-cycle unit, 4 = four-cycle unit).
  int lat = 4;
  int cnt = 0;

  always #5 clock = ~clock;

  xc_aessub_sched #(.NREQ(NREQ)) dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_rs1       (req_rs1),
    .req_rs2       (req_rs2),
    .req_enc       (req_enc),
    .req_rot       (req_rot),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .su_valid      (su_valid),
    .su_rs1        (su_rs1),
    .su_rs2        (su_rs2),
    .su_enc        (su_enc),
    .su_rot        (su_rot),
    .su_ready      (su_ready),
    .su_result     (su_result),
    .su_flush      (su_flush),
    .su_flush_data (su_flush_data),
    .busy          (busy),
    .owner         (owner)
  );

  // Small SubBytes unit model: only the bytes used by the vectors below.
  function automatic logic [7:0] sb(input logic [7:0] b);
    case (b)
      8'h00:   sb = 8'h63;
      8'h01:   sb = 8'h7c;
      8'h02:   sb = 8'h77;
      8'h10:   sb = 8'hca;
      8'h11:   sb = 8'h82;
      8'h53:   sb = 8'hed;
      default: sb = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] unit_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic enc, input logic rot);
    logic [31:0] x, r;
    x = a ^ b;
    r = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
    if (!enc) r = ~r;
    if (rot) r = {r[23:0], r[31:24]};
    return r;
  endfunction

  assign su_ready  = su_valid && (cnt == lat - 1);
  assign su_result = unit_fn(su_rs1, su_rs2, su_enc, su_rot);

  always @(posedge clock) begin
    if (reset || !su_valid || su_ready) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_rr, exp_rv;

    // Reset state
    tick; tick;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_req_ready", {30'd0, req_ready}, 0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("rst_su_valid", {31'd0, su_valid}, 0);
    chk("rst_su_flush", {31'd0, su_flush}, 0);
    chk("rst_owner", {31'd0, owner}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_su_rs1", su_rs1, 0);
    reset = 1'b0;
    tick;

    // Single request, four-cycle unit
    lat = 4;
    req_rs1 = {32'h0, 32'h00530001};
    req_rs2 = '0;
    req_enc = 2'b01;
    req_rot = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("t1_req_ready_c0", {30'd0, req_ready}, 32'h1);
    chk("t1_busy_c0", {31'd0, busy}, 0);
    chk("t1_su_valid_c0", {31'd0, su_valid}, 0);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t1_req_ready_c1", {30'd0, req_ready}, 0);
    chk("t1_owner", {31'd0, owner}, 0);
    chk("t1_su_rs1", su_rs1, 32'h00530001);
    chk("t1_su_enc", {31'd0, su_enc}, 1);
    chk("t1_su_rot", {31'd0, su_rot}, 0);
    chk("t1_su_flush_data", su_flush_data, 0);
    for (int c = 1; c <= 4; c++) begin
      chk("t1_su_valid_busy", {31'd0, su_valid}, 1);
      chk("t1_rsp_valid_busy", {30'd0, rsp_valid}, 0);
      tick;
    end
    chk("t1_rsp_valid_c5", {30'd0, rsp_valid}, 32'h1);
    chk("t1_rsp_data", rsp_data, 32'h63ed637c);
    chk("t1_su_valid_c5", {31'd0, su_valid}, 0);
    chk("t1_busy_c5", {31'd0, busy}, 1);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    #1;
    chk("t1_busy_after", {31'd0, busy}, 0);
    chk("t1_rsp_valid_after", {30'd0, rsp_valid}, 0);

    // Rotate, single-cycle unit (rr_ptr now 1, wraps to requester 0)
    lat = 1;
    req_rot = 2'b01;
    req_valid = 2'b01;
    #1;
    chk("t2_req_ready", {30'd0, req_ready}, 32'h1);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t2_su_valid", {31'd0, su_valid}, 1);
    chk("t2_su_rot", {31'd0, su_rot}, 1);
    tick;
    chk("t2_rsp_valid", {30'd0, rsp_valid}, 32'h1);
    chk("t2_rsp_data", rsp_data, 32'hed637c63);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;

    // Reset in RESP (rr_ptr was 1 before reset)
    lat = 4;
    req_rot = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("t6_req_ready", {30'd0, req_ready}, 32'h1);
    tick;
    req_valid = 2'b00;
    repeat (4) tick;
    chk("t6_rsp_valid_pre", {30'd0, rsp_valid}, 32'h1);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk("t6_busy", {31'd0, busy}, 0);
    chk("t6_rsp_valid", {30'd0, rsp_valid}, 0);
    chk("t6_su_valid", {31'd0, su_valid}, 0);
    chk("t6_rsp_data", rsp_data, 0);
    chk("t6_su_rs1", su_rs1, 0);
    chk("t6_su_enc", {31'd0, su_enc}, 0);

    // Contention: both requesting, rsp_ready high, rr_ptr reset to 0
    req_rs1 = {32'h00000010, 32'h00000001};
    req_rs2 = '0;
    req_enc = 2'b11;
    req_rot = 2'b00;
    rsp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int c = 0; c < 24; c++) begin
      exp_rr = (c % 6 == 0) ? (((c / 6) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      exp_rv = (c % 6 == 5) ? (((c / 6) % 2 == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("t3_req_ready", {30'd0, req_ready}, {30'd0, exp_rr});
      chk("t3_rsp_valid", {30'd0, rsp_valid}, {30'd0, exp_rv});
      if (c % 6 == 5) begin
        chk("t3_rsp_data", rsp_data, ((c / 6) % 2 == 1) ? 32'h636363ca : 32'h6363637c);
      end
      tick;
    end
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    chk("t3_busy_end", {31'd0, busy}, 0);

    // Response backpressure: requester 1 waits behind an un-acked response
    req_rs1 = {32'h01021110, 32'h53000100};
    req_rs2 = {32'h00000001, 32'h00000000};
    req_enc = 2'b01;
    req_rot = 2'b01;
    req_valid = 2'b11;
    #1;
    chk("t4_req_ready_c0", {30'd0, req_ready}, 32'h1);
    tick;
    req_valid = 2'b10;
    rsp_ready = 2'b10;
    repeat (4) tick;
    for (int i = 0; i < 10; i++) begin
      chk("t4_rsp_valid_hold", {30'd0, rsp_valid}, 32'h1);
      chk("t4_rsp_data_hold", rsp_data, 32'h637c63ed);
      chk("t4_req_ready_hold", {30'd0, req_ready}, 0);
      tick;
    end
    rsp_ready = 2'b11;
    #1;
    chk("t4_rsp_valid_ack", {30'd0, rsp_valid}, 32'h1);
    tick;
    rsp_ready = 2'b00;
    #1;
    chk("t4_req_ready_r1", {30'd0, req_ready}, 32'h2);
    chk("t4_busy_idle", {31'd0, busy}, 0);
    tick;
    req_valid = 2'b00;
    #1;
    chk("t4_owner_r1", {31'd0, owner}, 1);
    chk("t4_su_rs1_r1", su_rs1, 32'h01021110);
    chk("t4_su_rs2_r1", su_rs2, 32'h00000001);
    chk("t4_su_enc_r1", {31'd0, su_enc}, 0);
    repeat (4) tick;
    chk("t4_rsp_valid_r1", {30'd0, rsp_valid}, 32'h2);
    chk("t4_rsp_data_r1", rsp_data, 32'h83887d7d);
    rsp_ready = 2'b10;
    tick;
    rsp_ready = 2'b00;

    // Flush in the second BUSY cycle of a requester-0 operation (rr_ptr 0)
    req_rs1 = {32'h00000010, 32'h00530001};
    req_rs2 = '0;
    req_enc = 2'b01;
    req_rot = 2'b00;
    req_valid = 2'b01;
    #1;
    chk("t5_req_ready", {30'd0, req_ready}, 32'h1);
    tick;
    req_valid = 2'b00;
    tick;
    flush = 1'b1;
    #1;
`ifdef XC_AESSUB_SCHED_FLUSH_EN
    chk("t5_su_flush", {31'd0, su_flush}, 1);
    tick;
    flush = 1'b0;
    #1;
    chk("t5_busy_after", {31'd0, busy}, 0);
    chk("t5_su_valid_after", {31'd0, su_valid}, 0);
    for (int i = 0; i < 5; i++) begin
      chk("t5_no_rsp", {30'd0, rsp_valid}, 0);
      tick;
    end
    req_valid = 2'b11;
    #1;
    chk("t5_rr_ptr_kept", {30'd0, req_ready}, 32'h1);
`else
    chk("t5_su_flush_off", {31'd0, su_flush}, 0);
    tick;
    flush = 1'b0;
    #1;
    chk("t5_busy_kept", {31'd0, busy}, 1);
    chk("t5_su_valid_kept", {31'd0, su_valid}, 1);
    repeat (2) tick;
    chk("t5_rsp_valid", {30'd0, rsp_valid}, 32'h1);
    chk("t5_rsp_data", rsp_data, 32'h63ed637c);
    rsp_ready = 2'b01;
    tick;
    rsp_ready = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("t5_rr_ptr_next", {30'd0, req_ready}, 32'h2);
`endif
    tick;
    req_valid = 2'b00;
    repeat (3) tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
